// File: rtl/fifo_defines_pkg.sv
// Shared definitions for the FIFO read-side serial transmitter.
// Build option: FIFO_TX_PARITY_EN adds an even-parity bit between data and stop.
package fifo_defines_pkg;

  localparam int unsigned DATA_WIDTH   = 8;
  localparam int unsigned CLKS_PER_BIT = 16;
  localparam int unsigned TX_BIT_CNT_W = $clog2(DATA_WIDTH);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READ   = 3'd1,
    LATCH  = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    PARITY = 3'd5,
    STOP   = 3'd6
  } tx_state_t;

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period counter: tick is high on the last clock of each CLKS_PER_BIT period.
// clr restarts the period so every FSM state begins on a fresh bit boundary.
module baud_tick_gen
  import fifo_defines_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = fifo_defines_pkg::CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cnt <= '0;
    else if (clr || tick)
      cnt <= '0;
    else
      cnt <= cnt + CW'(1);
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/fifo_serial_tx.sv
// Pops one sample from the FIFO and sends it as start, LSB-first data, [parity], stop.
// Build option: FIFO_TX_PARITY_EN inserts an even-parity bit before the stop bit.
module fifo_serial_tx
  import fifo_defines_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = fifo_defines_pkg::DATA_WIDTH,
  parameter int unsigned CLKS_PER_BIT = fifo_defines_pkg::CLKS_PER_BIT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en_i,
  input  logic                         empty_i,
  output logic                         rd_en_o,
  input  logic signed [DATA_WIDTH-1:0] data_i,
  output logic                         tx_o,
  output logic                         busy_o,
  output logic                         done_o
);

  localparam int unsigned BW = $clog2(DATA_WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  tx_state_t             state, state_next;
  logic [DATA_WIDTH-1:0] shift;
  logic [BW-1:0]         bit_cnt;
  logic                  tick;
  logic                  clr;
`ifdef FIFO_TX_PARITY_EN
  logic                  parity;
`endif

  // Restart the bit period whenever the FSM enters a new state.
  assign clr = (state_next != state);

  baud_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .tick (tick)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (en_i && !empty_i) state_next = READ;
      READ:  state_next = LATCH;
      LATCH: state_next = START;
      START: if (tick) state_next = DATA;
      DATA: begin
        if (tick && bit_cnt == LAST_BIT) begin
`ifdef FIFO_TX_PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end
      end
`ifdef FIFO_TX_PARITY_EN
      PARITY: if (tick) state_next = STOP;
`endif
      STOP:  if (tick) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      shift   <= '0;
      bit_cnt <= '0;
`ifdef FIFO_TX_PARITY_EN
      parity  <= 1'b0;
`endif
    end else begin
      state <= state_next;
      if (state == LATCH) begin
        shift   <= data_i;
        bit_cnt <= '0;
`ifdef FIFO_TX_PARITY_EN
        parity  <= ^data_i;
`endif
      end else if (state == DATA && tick) begin
        shift   <= shift >> 1;
        bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + BW'(1);
      end
    end
  end

  always_comb begin
    tx_o = 1'b1;
    case (state)
      START:  tx_o = 1'b0;
      DATA:   tx_o = shift[0];
`ifdef FIFO_TX_PARITY_EN
      PARITY: tx_o = parity;
`endif
      default: tx_o = 1'b1;
    endcase
  end

  assign rd_en_o = (state == READ);
  assign busy_o  = (state != IDLE);
  assign done_o  = (state == STOP) && tick;

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Directed + random bench for fifo_serial_tx with a queue-based FIFO and a frame-level model.
// Build option: FIFO_TX_PARITY_EN must match the RTL build.
module tb_fifo_serial_tx;

  localparam int unsigned DW  = 8;
  localparam int unsigned CPB = 4;
`ifdef FIFO_TX_PARITY_EN
  localparam int unsigned NBITS = DW + 3;
`else
  localparam int unsigned NBITS = DW + 2;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en_i = 1'b0;
  logic          empty_i = 1'b1;
  logic [DW-1:0] data_i = '0;
  logic          rd_en_o, tx_o, busy_o, done_o;

  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned cyc = 0;
  logic [DW-1:0] fifo_q[$];

  always #5 clk = ~clk;

  fifo_serial_tx #(
    .DATA_WIDTH  (DW),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .en_i   (en_i),
    .empty_i(empty_i),
    .rd_en_o(rd_en_o),
    .data_i (data_i),
    .tx_o   (tx_o),
    .busy_o (busy_o),
    .done_o (done_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; the FIFO model answers a pop with registered (next-cycle) data.
  task automatic tick();
    logic pop;
    pop = rd_en_o;
    @(posedge clk);
    #1;
    cyc++;
    if (pop === 1'b1 && fifo_q.size() > 0) data_i = fifo_q.pop_front();
    else data_i = DW'($urandom);
    empty_i = (fifo_q.size() == 0);
  endtask

  task automatic push(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    empty_i = 1'b0;
  endtask

  // Line level for frame bit k: start, data LSB first, optional even parity, stop.
  function automatic logic exp_bit(input logic [DW-1:0] w, input int unsigned k);
    if (k == 0) return 1'b0;
    if (k <= DW) return w[k-1];
    if (k == NBITS - 1) return 1'b1;
    return ^w;
  endfunction

  task automatic expect_frame(input logic [DW-1:0] w, input int abort_at, input int drop_at,
                              output int unsigned pop_cyc);
    int unsigned n;
    n = 0;
    while (rd_en_o !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check("pop_seen", 32'(rd_en_o), 32'd1);
    pop_cyc = cyc;
    if (rd_en_o !== 1'b1) return;
    check("busy_read", 32'(busy_o), 32'd1);
    tick();
    check("rd_pulse_len", 32'(rd_en_o), 32'd0);
    check("tx_latch", 32'(tx_o), 32'd1);
    check("busy_latch", 32'(busy_o), 32'd1);
    for (int unsigned i = 0; i < NBITS * CPB; i++) begin
      tick();
      if (int'(i) == drop_at) en_i = 1'b0;
      if (int'(i) == abort_at) begin
        rst = 1'b0;
        #1;
        check("rst_tx", 32'(tx_o), 32'd1);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        return;
      end
      check("tx_bit", 32'(tx_o), 32'(exp_bit(w, i / CPB)));
      check("busy_frame", 32'(busy_o), 32'd1);
      check("done", 32'(done_o), 32'(i == NBITS * CPB - 1));
      check("rd_in_frame", 32'(rd_en_o), 32'd0);
    end
  endtask

  initial begin
    int unsigned p1, p2;
    logic [DW-1:0] w0, w1, w2;
    logic [DW-1:0] rw[4];

    #1;
    check("reset_tx", 32'(tx_o), 32'd1);
    check("reset_rd", 32'(rd_en_o), 32'd0);
    check("reset_busy", 32'(busy_o), 32'd0);
    check("reset_done", 32'(done_o), 32'd0);
    repeat (3) tick();
    rst = 1'b1;

    en_i = 1'b1;
    for (int unsigned i = 0; i < 100; i++) begin
      tick();
      check("empty_rd", 32'(rd_en_o), 32'd0);
      check("empty_tx", 32'(tx_o), 32'd1);
      check("empty_busy", 32'(busy_o), 32'd0);
    end

    push(8'hA5);
    expect_frame(8'hA5, -1, -1, p1);
    for (int unsigned i = 0; i < 10; i++) begin
      tick();
      check("single_no_repop", 32'(rd_en_o), 32'd0);
    end

    push(8'h01);
    push(8'h80);
    expect_frame(8'h01, -1, -1, p1);
    expect_frame(8'h80, -1, -1, p2);
    check("b2b_spacing", p2 - p1, NBITS * CPB + 3);

    w0 = DW'($urandom);
    w1 = DW'($urandom);
    w2 = DW'($urandom);
    push(w0);
    push(w1);
    push(w2);
    expect_frame(w0, -1, 1, p1);
    for (int unsigned i = 0; i < 60; i++) begin
      tick();
      check("drop_no_pop", 32'(rd_en_o), 32'd0);
      check("drop_idle", 32'(busy_o), 32'd0);
    end
    check("drop_fifo_left", fifo_q.size(), 32'd2);
    en_i = 1'b1;
    expect_frame(w1, -1, -1, p1);
    expect_frame(w2, -1, -1, p1);
    for (int unsigned i = 0; i < 5; i++) tick();

    push(8'hA5);
    push(8'h3C);
    expect_frame(8'hA5, int'(4 * CPB + 1), -1, p1);
    repeat (2) begin
      tick();
      check("rst_hold_rd", 32'(rd_en_o), 32'd0);
      check("rst_hold_tx", 32'(tx_o), 32'd1);
    end
    rst = 1'b1;
    expect_frame(8'h3C, -1, -1, p1);

    for (int unsigned i = 0; i < 4; i++) begin
      rw[i] = DW'($urandom);
      push(rw[i]);
    end
    for (int unsigned i = 0; i < 4; i++) expect_frame(rw[i], -1, -1, p1);
    for (int unsigned i = 0; i < 5; i++) begin
      tick();
      check("drain_idle", 32'(busy_o), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
